// File: rtl/keccak_pkg.sv
// keccak_pkg: shared constants, types and helpers for the SHAKE core.
//   w              data word width
//   RATE_SHAKE128  rate in bits for SHAKE128 (21 words)
//   RATE_SHAKE256  rate in bits for SHAKE256 (17 words)
//   MODE_*         operation mode encodings
//   PAD_*          SHAKE padding bytes
//   load_state_t   FSM states of load_pad_stage
package keccak_pkg;

  localparam int w             = 64;
  localparam int RATE_SHAKE128 = 1344;
  localparam int RATE_SHAKE256 = 1088;

  localparam logic [1:0] MODE_SHAKE128 = 2'b00;
  localparam logic [1:0] MODE_SHAKE256 = 2'b01;

  localparam logic [7:0] PAD_DOMAIN = 8'h1F;
  localparam logic [7:0] PAD_FINAL  = 8'h80;

  typedef enum logic [1:0] {
    LOAD_IDLE    = 2'b00,
    LOAD_FILL    = 2'b01,
    LOAD_HANDOFF = 2'b10
  } load_state_t;

  // Number of rate words for a mode; reserved codes behave as SHAKE256.
  function automatic logic [4:0] rate_words(input logic [1:0] mode);
    logic [4:0] rw;
    if (mode == MODE_SHAKE128) begin
      rw = 5'd21;
    end else begin
      rw = 5'd17;
    end
    return rw;
  endfunction

  // Keep the bytes below nb, place the domain pad byte at nb, zero the rest.
  function automatic logic [63:0] pad_partial(input logic [63:0] data, input logic [2:0] nb);
    logic [63:0] res;
    res = 64'd0;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(nb)) begin
        res[8*k +: 8] = data[8*k +: 8];
      end else if (k == int'(nb)) begin
        res[8*k +: 8] = PAD_DOMAIN;
      end else begin
        res[8*k +: 8] = 8'h00;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/latch.sv
// latch: registered set/clear flag; set has priority over clear.
//   clk, rst  clock and asynchronous active-high reset
//   set       force flag to 1 on the next edge
//   clr       force flag to 0 on the next edge (ignored when set is high)
//   q         flag value
module latch (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic q
);

  // Flag register with set-over-clear priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (set) begin
      q <= 1'b1;
    end else if (clr) begin
      q <= 1'b0;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/load_pad_stage.sv
// load_pad_stage: accepts a header word then message words, packs them into a
// rate-wide block with SHAKE padding and hands each block downstream.
//   clk, rst                  clock, asynchronous active-high reset
//   valid_in/ready_out        word stream handshake
//   data_in, mode_in          header or message word; mode sampled with header
//   rate_input                held block, word i at [64i+63:64i]
//   output_size               requested output length (bits)
//   operation_mode            normalised mode of the held message
//   input_buffer_ready        rate_input holds an unconsumed block
//   last_block_in_buffer      held block is the final one of its message
//   input_buffer_ready_clr    downstream consumed the block
//   last_block_in_buffer_clr  downstream clears the last-block flag
module load_pad_stage
  import keccak_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic [w-1:0]             data_in,
  input  logic [1:0]               mode_in,
  output logic [RATE_SHAKE128-1:0] rate_input,
  output logic [31:0]              output_size,
  output logic [1:0]               operation_mode,
  output logic                     input_buffer_ready,
  output logic                     last_block_in_buffer,
  input  logic                     input_buffer_ready_clr,
  input  logic                     last_block_in_buffer_clr
);

  load_state_t              state_r, state_nx_s;
  logic [4:0]               slot_r, slot_nx_s;
  logic [31:0]              rem_r, rem_nx_s;
  logic                     padded_r, padded_nx_s;
  logic                     first_r;
  logic                     ready_r, ready_nx_s;
  logic [RATE_SHAKE128-1:0] work_r;
  logic [RATE_SHAKE128-1:0] rate_input_r;
  logic [31:0]              shadow_size_r;
  logic [1:0]               shadow_mode_r;
  logic [31:0]              output_size_r;
  logic [1:0]               operation_mode_r;

  logic                     accept_s;
  logic                     hdr_s;
  logic                     word_we_s;
  logic [w-1:0]             word_s;
  logic                     copy_s;
  logic                     last_set_s;
  logic [4:0]               last_slot_s;
  logic                     ibr_q_s;
  logic                     last_q_s;

  assign accept_s    = valid_in & ready_r;
  assign last_slot_s = rate_words(shadow_mode_r) - 5'd1;
  assign last_set_s  = copy_s & padded_r;

  // Next-state, slot word generation and handoff decision.
  always_comb begin
    state_nx_s  = state_r;
    slot_nx_s   = slot_r;
    rem_nx_s    = rem_r;
    padded_nx_s = padded_r;
    hdr_s       = 1'b0;
    word_we_s   = 1'b0;
    word_s      = 64'd0;
    copy_s      = 1'b0;
    case (state_r)
      LOAD_IDLE: begin
        if (accept_s) begin
          hdr_s       = 1'b1;
          state_nx_s  = LOAD_FILL;
          slot_nx_s   = 5'd0;
          rem_nx_s    = {data_in[31:3], 3'b000};
          padded_nx_s = 1'b0;
        end else begin
          state_nx_s = LOAD_IDLE;
        end
      end
      LOAD_FILL: begin
        if (rem_r >= 32'd64) begin
          if (accept_s) begin
            word_s    = data_in;
            word_we_s = 1'b1;
            rem_nx_s  = rem_r - 32'd64;
          end else begin
            word_we_s = 1'b0;
          end
        end else if (rem_r != 32'd0) begin
          if (accept_s) begin
            word_s      = pad_partial(data_in, rem_r[5:3]);
            word_we_s   = 1'b1;
            rem_nx_s    = 32'd0;
            padded_nx_s = 1'b1;
          end else begin
            word_we_s = 1'b0;
          end
        end else if (!padded_r) begin
          // Message ended on a word boundary: pad word inserted without handshake.
          word_s      = {56'd0, PAD_DOMAIN};
          word_we_s   = 1'b1;
          padded_nx_s = 1'b1;
        end else begin
          word_s    = 64'd0;
          word_we_s = 1'b1;
        end
        // Final rate byte carries the closing pad bit once padding has started.
        if (word_we_s && (slot_r == last_slot_s) && padded_nx_s) begin
          word_s[63:56] = word_s[63:56] | PAD_FINAL;
        end else begin
          word_s = word_s;
        end
        if (word_we_s) begin
          if (slot_r == last_slot_s) begin
            state_nx_s = LOAD_HANDOFF;
            slot_nx_s  = 5'd0;
          end else begin
            slot_nx_s = slot_r + 5'd1;
          end
        end else begin
          slot_nx_s = slot_r;
        end
      end
      LOAD_HANDOFF: begin
        if (!ibr_q_s || input_buffer_ready_clr) begin
          copy_s     = 1'b1;
          slot_nx_s  = 5'd0;
          state_nx_s = padded_r ? LOAD_IDLE : LOAD_FILL;
        end else begin
          copy_s = 1'b0;
        end
      end
      default: begin
        state_nx_s = LOAD_IDLE;
      end
    endcase
    ready_nx_s = (state_nx_s == LOAD_IDLE) ||
                 ((state_nx_s == LOAD_FILL) && (rem_nx_s != 32'd0));
  end

  // FSM state, working register, shadow header fields and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= LOAD_IDLE;
      slot_r           <= 5'd0;
      rem_r            <= 32'd0;
      padded_r         <= 1'b0;
      first_r          <= 1'b0;
      ready_r          <= 1'b0;
      work_r           <= '0;
      rate_input_r     <= '0;
      shadow_size_r    <= 32'd0;
      shadow_mode_r    <= 2'b00;
      output_size_r    <= 32'd0;
      operation_mode_r <= 2'b00;
    end else begin
      state_r  <= state_nx_s;
      slot_r   <= slot_nx_s;
      rem_r    <= rem_nx_s;
      padded_r <= padded_nx_s;
      ready_r  <= ready_nx_s;
      if (hdr_s) begin
        // Clearing here keeps words beyond a SHAKE256 rate at zero.
        work_r        <= '0;
        shadow_size_r <= data_in[63:32];
        shadow_mode_r <= (mode_in == MODE_SHAKE128) ? MODE_SHAKE128 : MODE_SHAKE256;
        first_r       <= 1'b1;
      end else if (word_we_s) begin
        work_r[{slot_r, 6'd0} +: 64] <= word_s;
      end else begin
        work_r <= work_r;
      end
      if (copy_s) begin
        rate_input_r <= work_r;
        if (first_r) begin
          output_size_r    <= shadow_size_r;
          operation_mode_r <= shadow_mode_r;
          first_r          <= 1'b0;
        end else begin
          output_size_r    <= output_size_r;
          operation_mode_r <= operation_mode_r;
        end
      end else begin
        rate_input_r <= rate_input_r;
      end
    end
  end

  latch u_ibr_latch (
    .clk (clk),
    .rst (rst),
    .set (copy_s),
    .clr (input_buffer_ready_clr),
    .q   (ibr_q_s)
  );

  latch u_last_latch (
    .clk (clk),
    .rst (rst),
    .set (last_set_s),
    .clr (last_block_in_buffer_clr),
    .q   (last_q_s)
  );

  assign ready_out            = ready_r;
  assign rate_input           = rate_input_r;
  assign output_size          = output_size_r;
  assign operation_mode       = operation_mode_r;
  assign input_buffer_ready   = ibr_q_s;
  assign last_block_in_buffer = last_q_s;

endmodule

// File: doc/load_pad_stage.md
# load_pad_stage

First pipeline stage of the SHAKE core, directly upstream of `permute_dump_stage`. It accepts a header word and then message words on a valid/ready stream. It packs the message into a rate-wide block buffer and applies SHAKE padding (0x1F … 0x80). Each completed block is handed to the permute stage through the `input_buffer_ready` / `last_block_in_buffer` set/clear latches.

## Interface
Parameters (from `keccak_pkg`, not overridable):
- `w`, 64: data word width.
- `RATE_SHAKE128`, 1344: rate width in bits (21 words).
- `RATE_SHAKE256`, 1088: rate width in bits (17 words).

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset; asynchronous, active-high.
- `valid_in`  in  1  `data_in` and `mode_in` are valid.
- `ready_out`  out  1  stage accepts a word this cycle.
- `data_in`  in  w  header word or message word.
- `mode_in`  in  2  operation mode; sampled with the header word only.
- `rate_input`  out  RATE_SHAKE128  block buffer; word i sits at bits [64i+63:64i].
- `output_size`  out  32  requested output length in bits.
- `operation_mode`  out  2  `MODE_SHAKE128` = 2'b00, `MODE_SHAKE256` = 2'b01; reserved codes are treated as SHAKE256.
- `input_buffer_ready`  out  1  `rate_input` holds an unconsumed block.
- `last_block_in_buffer`  out  1  the held block is the final message block.
- `input_buffer_ready_clr`  in  1  from downstream: block consumed.
- `last_block_in_buffer_clr`  in  1  from downstream: clear the last-block flag.

## Operation
- Header word layout: [31:0] `input_size` in bits, [63:32] `output_size`. `input_size[2:0]` is ignored, so messages are byte-granular.
- Byte order is little-endian: message byte k of a word sits at bits [8k+7:8k].
- Rate words: RW = 21 for SHAKE128, 17 for SHAKE256. Words RW..20 of `rate_input` are driven as zero.
- FSM states:
  - IDLE: `ready_out` = 1. Header handshake latches `input_size`, shadow `output_size` and shadow mode. Go to FILL.
  - FILL: slot counter s runs 0..RW-1 over the working register; `rem` holds the remaining message bits.
    - rem ≥ 64: accept the word (`ready_out` = 1); rem -= 64.
    - 0 < rem < 64: accept the word. Keep bytes below rem/8, put 0x1F at byte rem/8, zero the upper bytes, set `padded`, rem = 0.
    - rem = 0 and not `padded`: `ready_out` = 0. Insert word 0x…001F with no handshake; set `padded`.
    - `padded` already set: insert a zero word.
    - On slot RW-1 with `padded` set: OR 0x80 into byte 7 (giving 0x9F if 0x1F landed there).
    - After slot RW-1 completes, go to HANDOFF.
  - HANDOFF: `ready_out` = 0. Copy the working register to `rate_input` when `input_buffer_ready` = 0 or `input_buffer_ready_clr` = 1.
    - On copy, set `input_buffer_ready`. Set `last_block_in_buffer` if `padded`.
    - On the first block of a message, also transfer the shadow size and mode to `output_size` / `operation_mode`.
    - Next state: IDLE if `padded`, else FILL with s = 0.
- A message that ends exactly on a block boundary produces an extra block containing only padding.
- An `input_size` of 0 produces a single pad-only block.
- Both flags use `latch` instances. If set and clear arrive in the same cycle, set wins.
- Reset mid-operation drops all partial state and returns to IDLE.

## Timing
- All outputs reset to 0; the FSM resets to IDLE.
- Throughput is 1 message word per cycle in FILL. Pad-only slots take 1 cycle each without a handshake.
- The header costs 1 cycle. HANDOFF costs a minimum of 1 cycle.
- `rate_input` and the flags update on the clock edge that ends HANDOFF. They are visible the next cycle.
- `rate_input`, `output_size` and `operation_mode` stay stable while `input_buffer_ready` = 1.
- The next header may be accepted while the previous last block is still held downstream.
- `ready_out` is a registered-state decode. It never depends combinationally on `valid_in`.
- Size arithmetic is 32-bit unsigned. rem never underflows (partial-word branch).

## Structure
- Add to `keccak_pkg`: `RATE_SHAKE256`, `MODE_SHAKE128`, `MODE_SHAKE256`, `PAD_DOMAIN` = 8'h1F, `PAD_FINAL` = 8'h80, and a `load_state_t` enum.
- Reuse the existing `latch` sub-module for both handoff flags. Everything else stays in one module, roughly 250 lines.

## Test plan
- SHAKE128, `input_size` = 0: expect one block. Word 0 = 0x1F, word 20 = 0x8000000000000000, `last_block_in_buffer` = 1.
- SHAKE128, 1344-bit message: block 1 is all data with last = 0. Block 2 is pad-only (0x1F … 0x80) with last = 1.
- SHAKE256, 1080-bit message: word 16 byte 7 = 0x9F. `rate_input` bits ≥ 1088 are zero.
- SHAKE128, 72-bit message: word 0 = data, word 1 = 0x1F00 | byte 8. `output_size` and mode appear only with block 1.
- Hold `input_buffer_ready_clr` low for 10 cycles after a full block: `ready_out` stays 0 and `rate_input` is unchanged. Pulse clr: copy occurs on that edge.
- Assert `rst` in FILL mid-message: all outputs go to 0 immediately. A new header is then accepted cleanly.
